// File: rtl/bcd_sevenseg_scan_pkg.sv
// Shared constants and types for the 4-digit BCD seven-segment scanner.
// All segment patterns are active-low in {g,f,e,d,c,b,a} order; anodes are
// active-low with bit k enabling digit k.
package bcd_sevenseg_scan_pkg;

  localparam logic [6:0] SEG_0    = 7'h40;
  localparam logic [6:0] SEG_1    = 7'h79;
  localparam logic [6:0] SEG_2    = 7'h24;
  localparam logic [6:0] SEG_3    = 7'h30;
  localparam logic [6:0] SEG_4    = 7'h19;
  localparam logic [6:0] SEG_5    = 7'h12;
  localparam logic [6:0] SEG_6    = 7'h02;
  localparam logic [6:0] SEG_7    = 7'h78;
  localparam logic [6:0] SEG_8    = 7'h00;
  localparam logic [6:0] SEG_9    = 7'h10;
  localparam logic [6:0] SEG_DASH = 7'h3F;
  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [3:0] AN_OFF   = 4'b1111;

  typedef logic [1:0] digit_idx_t;

  // One registered display frame: what the pins show this cycle.
  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } disp_t;

  localparam disp_t DISP_OFF = '{an: AN_OFF, seg: SEG_OFF, dp: 1'b1};

endpackage

// File: rtl/bcd_sevenseg_scan_if.sv
// Bus between the BCD source / display pins and the scanner.
// Handshake: bcd_valid is a single-cycle strobe with no ready; the scanner
// always accepts, capturing packed_bcd on every rising edge where bcd_valid=1.
// blank_lz and dp_mask are level controls sampled every cycle.
// Signals:
//   packed_bcd [15:0]  digit3=[15:12] .. digit0=[3:0]
//   bcd_valid          capture strobe
//   blank_lz           leading-zero blanking enable
//   dp_mask    [3:0]   decimal point request per digit (1 = lit)
//   an         [3:0]   anodes, active-low
//   seg        [6:0]   {g,f,e,d,c,b,a}, active-low
//   dp                 decimal point, active-low
interface bcd_sevenseg_scan_if;
  logic [15:0] packed_bcd;
  logic        bcd_valid;
  logic        blank_lz;
  logic [3:0]  dp_mask;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  modport master (
    output packed_bcd, bcd_valid, blank_lz, dp_mask,
    input  an, seg, dp
  );

  modport slave (
    input  packed_bcd, bcd_valid, blank_lz, dp_mask,
    output an, seg, dp
  );
endinterface

// File: rtl/bcd_to_7seg.sv
// Combinational BCD nibble to active-low seven-segment decoder.
// Nibbles A-F are not valid BCD and show a dash.
// Ports:
//   nibble_i [3:0]  BCD digit
//   seg_o    [6:0]  {g,f,e,d,c,b,a}, active-low
module bcd_to_7seg
  import bcd_sevenseg_scan_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    case (nibble_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_sevenseg_scan.sv
// 4-digit common-anode multiplexed seven-segment driver for packed BCD.
// Captures packed_bcd on bcd_valid, scans one digit per REFRESH_DIV-cycle slot
// with DEAD_CYC all-off cycles at the start of each slot (anti-ghosting), and
// optionally blanks leading zeros. Outputs are registered: the pins reflect
// the held value, controls, digit index and slot counter of the previous cycle.
// Parameters:
//   REFRESH_DIV  clk cycles per digit slot (>= DEAD_CYC+1)
//   DEAD_CYC     all-anodes-off cycles at slot start (0 = none)
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      slave side of bcd_sevenseg_scan_if (BCD in, display pins out)
module bcd_sevenseg_scan
  import bcd_sevenseg_scan_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int DEAD_CYC    = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  bcd_sevenseg_scan_if.slave   bus
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [15:0]      held_q, held_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  digit_idx_t       idx_q, idx_d;
  disp_t            out_q, out_d;

  logic       slot_end;
  logic       dead;
  logic [3:0] nib;
  logic       lz_blank;
  logic [6:0] dec_seg;

  assign slot_end = (cnt_q == CNT_W'(REFRESH_DIV - 1));

  generate
    if (DEAD_CYC > 0) begin : g_dead
      assign dead = (cnt_q < CNT_W'(DEAD_CYC));
    end else begin : g_no_dead
      assign dead = 1'b0;
    end
  endgenerate

  always_comb begin
    held_d = bus.bcd_valid ? bus.packed_bcd : held_q;
    cnt_d  = slot_end ? '0 : cnt_q + 1'b1;
    idx_d  = slot_end ? idx_q + 1'b1 : idx_q;
  end

  // Current digit and whether it is a leading zero: the digit and every
  // digit above it are zero. Digit 0 is always shown; A-F counts as nonzero.
  always_comb begin
    nib      = held_q[3:0];
    lz_blank = 1'b0;
    case (idx_q)
      2'd0: begin
        nib      = held_q[3:0];
        lz_blank = 1'b0;
      end
      2'd1: begin
        nib      = held_q[7:4];
        lz_blank = (held_q[15:4] == 12'h000);
      end
      2'd2: begin
        nib      = held_q[11:8];
        lz_blank = (held_q[15:8] == 8'h00);
      end
      default: begin
        nib      = held_q[15:12];
        lz_blank = (held_q[15:12] == 4'h0);
      end
    endcase
  end

  bcd_to_7seg u_dec (
    .nibble_i (nib),
    .seg_o    (dec_seg)
  );

  // A blanked digit keeps its anode and decimal point; only segments go dark.
  always_comb begin
    out_d = DISP_OFF;
    if (!dead) begin
      out_d.an  = ~(4'b0001 << idx_q);
      out_d.seg = (bus.blank_lz && lz_blank) ? SEG_OFF : dec_seg;
      out_d.dp  = ~bus.dp_mask[idx_q];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      held_q <= 16'h0000;
      cnt_q  <= '0;
      idx_q  <= '0;
      out_q  <= DISP_OFF;
    end else begin
      held_q <= held_d;
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      out_q  <= out_d;
    end
  end

  assign bus.an  = out_q.an;
  assign bus.seg = out_q.seg;
  assign bus.dp  = out_q.dp;

endmodule

// File: tb/tb_bcd_sevenseg_scan.sv
module tb_bcd_sevenseg_scan;

  localparam int R = 8;
  localparam int D = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  bcd_sevenseg_scan_if bus ();

  bcd_sevenseg_scan #(
    .REFRESH_DIV (R),
    .DEAD_CYC    (D)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  int checks = 0;
  int failures = 0;
  logic [11:0] exp_q[$];
  logic [6:0]  seg_tab[16];
  logic [15:0] m_held;
  int          m_t;   // rising edges since reset release

  // Display after the edge that follows t elapsed edges: slot = t/R,
  // position in slot = t%R, digit cycles through 0..3 with each slot.
  function automatic logic [11:0] model_out(logic [15:0] held, logic blz,
                                            logic [3:0] dpm, int t);
    int cnt, idx, upper;
    logic [3:0] an;
    logic [6:0] seg;
    cnt = t % R;
    idx = (t / R) % 4;
    if (cnt < D) return {4'hF, 7'h7F, 1'b1};
    upper = int'(held) >> (4 * idx);
    an = 4'hF;
    an[idx] = 1'b0;
    if (blz && idx != 0 && upper == 0) seg = 7'h7F;
    else seg = seg_tab[upper & 15];
    return {an, seg, ~dpm[idx]};
  endfunction

  function automatic logic [15:0] to_bcd(int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h (an,seg,dp)", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic v, input logic [15:0] bcd, input logic blz,
                      input logic [3:0] dpm, input string tag);
    bus.bcd_valid  = v;
    bus.packed_bcd = bcd;
    bus.blank_lz   = blz;
    bus.dp_mask    = dpm;
    exp_q.push_back(model_out(m_held, blz, dpm, m_t));
    @(posedge clk);
    if (v) m_held = bcd;
    m_t++;
    #1;
    chk(tag, {bus.an, bus.seg, bus.dp}, exp_q.pop_front());
  endtask

  task automatic run(input int n, input logic blz, input logic [3:0] dpm, input string tag);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0000, blz, dpm, tag);
  endtask

  task automatic load(input logic [15:0] bcd, input logic blz, input logic [3:0] dpm,
                      input string tag);
    step(1'b1, bcd, blz, dpm, tag);
    run(4 * R + 1, blz, dpm, tag);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
    bus.bcd_valid  = 1'b0;
    bus.packed_bcd = 16'h0000;
    bus.blank_lz   = 1'b0;
    bus.dp_mask    = 4'h0;
    m_held = 16'h0000;
    m_t    = 0;

    // 1: reset held for 5 cycles
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("reset_hold", {bus.an, bus.seg, bus.dp}, {4'hF, 7'h7F, 1'b1});
    end
    @(negedge clk);
    reset_n = 1'b1;
    m_t = 0;
    m_held = 16'h0000;
    run(3, 1'b0, 4'h0, "first_slot");
    chk("first_digit0", {bus.an, bus.seg, bus.dp}, {4'hE, 7'h40, 1'b1});
    run(4 * R, 1'b0, 4'h0, "zero_frame");

    // 2: 1234, all digits shown
    load(16'h1234, 1'b0, 4'h0, "val_1234");

    // 3: leading-zero blanking
    load(16'h0007, 1'b1, 4'h0, "val_0007_lz");
    load(16'h0000, 1'b1, 4'h0, "val_0000_lz");
    load(16'h0105, 1'b1, 4'h0, "val_0105_lz");
    load(16'h0105, 1'b0, 4'h0, "val_0105_nolz");

    // 4: illegal nibble as dash, decimal point on digit 1
    load(16'h00A9, 1'b1, 4'b0010, "val_00a9_dp");

    // 5: back-to-back valids mid-slot; last one wins
    while ((m_t % R) != 4) step(1'b0, 16'h0000, 1'b1, 4'h0, "align_b2b");
    step(1'b1, 16'h1111, 1'b1, 4'h0, "b2b_first");
    step(1'b1, 16'h9999, 1'b1, 4'h0, "b2b_second");
    run(4 * R + 2, 1'b1, 4'h0, "b2b_after");

    // 6: reset mid-scan during digit 2 at counter 5
    while (!(((m_t / R) % 4) == 2 && (m_t % R) == 5))
      step(1'b0, 16'h0000, 1'b0, 4'hF, "align_rst");
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_async", {bus.an, bus.seg, bus.dp}, {4'hF, 7'h7F, 1'b1});
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("rst_mid_hold", {bus.an, bus.seg, bus.dp}, {4'hF, 7'h7F, 1'b1});
    end
    @(negedge clk);
    reset_n = 1'b1;
    m_t = 0;
    m_held = 16'h0000;
    run(2, 1'b0, 4'hF, "rst_dead");
    run(1, 1'b0, 4'hF, "rst_resume");
    chk("rst_resume_d0", {bus.an, bus.seg, bus.dp}, {4'hE, 7'h40, 1'b0});
    run(4 * R, 1'b0, 4'hF, "rst_frame");

    // Sweep: random decimal values through their BCD form
    for (int i = 0; i < 40; i++) begin
      int v;
      v = $urandom_range(0, 9999);
      load(to_bcd(v), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), "sweep_dec");
    end
    load(to_bcd(9999), 1'b1, 4'h0, "sweep_9999");
    load(to_bcd(10), 1'b1, 4'h0, "sweep_10");

    // Raw nibbles including A-F in any position
    for (int i = 0; i < 10; i++) begin
      load(16'($urandom), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), "sweep_raw");
    end

    // Controls change cycle by cycle without a new capture
    for (int i = 0; i < 3 * 4 * R; i++) begin
      step(1'b0, 16'h0000, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), "ctl_toggle");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
